// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer.
//   muldiv_op_t  : 3-bit EX opcode for HI/LO-writing instructions
//   hilo_state_t : controller FSM states
//   DIV_STEPS    : iterations of the restoring divider
//   abs32        : magnitude of a 32-bit value, optionally signed
package hilo_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } hilo_state_t;

  localparam int unsigned DIV_STEPS = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed & v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_ctrl_div_iter.sv
// div_iter: radix-2 restoring divider, 32 steps, signed or unsigned.
//   clk, resetn : clock, synchronous active-low reset
//   clear       : abort any division in progress
//   start       : latch a/b/is_signed and begin (one-cycle pulse)
//   is_signed   : treat a and b as two's complement
//   a, b        : dividend, divisor
//   done        : one-cycle pulse exactly 32 cycles after start
//   q, r        : quotient and remainder, valid while done is high
// Divide by zero gives q=all ones, r=a. The signed overflow case
// 0x8000_0000 / -1 falls out of the magnitude path as q=0x8000_0000, r=0.
module div_iter
  import hilo_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [31:0] r_a;
  logic [4:0]  r_cnt;
  logic        r_run;
  logic        r_done;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits.
  function automatic logic [63:0] div_step(input logic [31:0] rem,
                                           input logic [31:0] quo,
                                           input logic [31:0] dvs);
    logic [32:0] t;
    logic [32:0] d;
    t = {rem, quo[31]};
    d = {1'b0, dvs};
    if (t >= d) return {32'(t - d), quo[30:0], 1'b1};
    else        return {t[31:0], quo[30:0], 1'b0};
  endfunction

  assign w_abs_a = abs32(a, is_signed);
  assign w_abs_b = abs32(b, is_signed);

  // The first step is taken on the start edge so the 32nd step lands on
  // the edge before done, giving a done pulse exactly 32 cycles later.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_a     <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clear) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else if (start) begin
        {r_rem, r_quo} <= div_step('0, w_abs_a, w_abs_b);
        r_div   <= w_abs_b;
        r_a     <= a;
        r_cnt   <= 5'(DIV_STEPS - 1);
        r_run   <= 1'b1;
        r_neg_q <= is_signed & (a[31] ^ b[31]);
        r_neg_r <= is_signed & a[31];
        r_dz    <= (b == '0);
      end else if (r_run) begin
        {r_rem, r_quo} <= div_step(r_rem, r_quo, r_div);
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign q    = r_dz ? '1  : (r_neg_q ? (~r_quo + 32'd1) : r_quo);
  assign r    = r_dz ? r_a : (r_neg_r ? (~r_rem + 32'd1) : r_rem);

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequencer for the HI/LO register pair.
//   clk, resetn          : clock, synchronous active-low reset
//   req_valid/req_op     : HI/LO-writing op from EX (muldiv_op_t encoding)
//   src_a, src_b         : rs / rt operands
//   req_ready            : op accepted when req_valid & req_ready
//   flush                : abort in-flight op, suppress any write this cycle
//   rd_hilo              : MFHI/MFLO in EX
//   stall                : rd_hilo while an op is in flight
//   busy                 : op in flight
//   hi_we/lo_we          : HI/LO write enables
//   hi_data/lo_data      : HI/LO write data (result registers when idle)
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        req_ready,
  input  logic        flush,
  input  logic        rd_hilo,
  output logic        stall,
  output logic        busy,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  hilo_state_t r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_signed;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;

  muldiv_op_t  w_op;
  logic        w_accept;
  logic        w_div_start;
  logic        w_div_done;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [63:0] w_ea;
  logic [63:0] w_eb;
  logic [63:0] w_prod;

  assign w_op        = muldiv_op_t'(req_op);
  assign req_ready   = (r_state == S_IDLE) & ~flush;
  assign w_accept    = req_valid & req_ready;
  assign w_div_start = w_accept & ((w_op == OP_DIV) | (w_op == OP_DIVU));
  assign busy        = (r_state != S_IDLE);
  assign stall       = rd_hilo & busy;

  // Sign- or zero-extending both operands to 64 bits lets a single
  // unsigned multiply serve MULT and MULTU.
  assign w_ea   = {{32{r_signed & r_a[31]}}, r_a};
  assign w_eb   = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod = w_ea * w_eb;

  div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (flush),
    .start     (w_div_start),
    .is_signed (w_op == OP_DIV),
    .a         (src_a),
    .b         (src_b),
    .done      (w_div_done),
    .q         (w_q),
    .r         (w_r)
  );

  always_comb begin
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_data = r_res_hi;
    lo_data = r_res_lo;
    if (w_accept && (w_op == OP_MTHI)) begin
      hi_we   = 1'b1;
      hi_data = src_a;
    end
    if (w_accept && (w_op == OP_MTLO)) begin
      lo_we   = 1'b1;
      lo_data = src_a;
    end
    if ((r_state == S_DONE) && !flush) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept && ((w_op == OP_MULT) || (w_op == OP_MULTU))) begin
            r_state  <= S_MUL;
            r_cnt    <= 4'(MUL_CYCLES - 1);
            r_a      <= src_a;
            r_b      <= src_b;
            r_signed <= (w_op == OP_MULT);
          end else if (w_div_start) begin
            r_state <= S_DIV;
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            r_res_hi <= w_prod[63:32];
            r_res_lo <= w_prod[31:0];
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            r_res_hi <= w_r;
            r_res_lo <= w_q;
            r_state  <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;

  localparam int MC = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        rd_hilo = 1'b0;
  logic        req_ready;
  logic        stall;
  logic        busy;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_data;
  logic [31:0] lo_data;

  hilo_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_op    (req_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .req_ready (req_ready),
    .flush     (flush),
    .rd_hilo   (rd_hilo),
    .stall     (stall),
    .busy      (busy),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .hi_data   (hi_data),
    .lo_data   (lo_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint p;
    logic [63:0] u;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); return p; end
      3'd2: begin u = {32'd0, a} * {32'd0, b}; return u; end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  // Behavioural model: an accepted MULT/DIV occupies the next L cycles
  // (L = MC+1 or 33); the last of those is the write cycle, and the visible
  // result registers change on the edge before it.
  int          m_rem = 0;
  bit          mvalid = 0;
  logic [31:0] m_shown_hi = '0, m_shown_lo = '0;
  logic [31:0] m_pend_hi = '0, m_pend_lo = '0;

  int          cyc = 0;
  int          wr_count = 0;
  int          wr_cyc = 0;
  logic [31:0] last_hi = '0, last_lo = '0;
  int          lo_only = 0;
  logic [31:0] last_lo_only = '0;
  int          stall_cnt = 0;

  always @(negedge clk) begin
    logic e_busy, e_ready, e_acc, e_hwe, e_lwe;
    logic [31:0] e_hd, e_ld;
    cyc++;
    e_busy  = (m_rem > 0);
    e_ready = !e_busy && !flush;
    e_acc   = req_valid && e_ready;
    e_hwe = 1'b0; e_lwe = 1'b0;
    e_hd  = m_shown_hi; e_ld = m_shown_lo;
    if (e_acc && req_op == 3'd5) begin e_hwe = 1'b1; e_hd = src_a; end
    if (e_acc && req_op == 3'd6) begin e_lwe = 1'b1; e_ld = src_a; end
    if (m_rem == 1 && !flush) begin e_hwe = 1'b1; e_lwe = 1'b1; end
    if (mvalid) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
      chk("busy",      {31'd0, busy},      {31'd0, e_busy});
      chk("stall",     {31'd0, stall},     {31'd0, rd_hilo & e_busy});
      chk("hi_we",     {31'd0, hi_we},     {31'd0, e_hwe});
      chk("lo_we",     {31'd0, lo_we},     {31'd0, e_lwe});
      chk("hi_data",   hi_data,            e_hd);
      chk("lo_data",   lo_data,            e_ld);
    end
    if (hi_we && lo_we) begin
      wr_count++; wr_cyc = cyc; last_hi = hi_data; last_lo = lo_data;
    end else if (lo_we) begin
      lo_only++; last_lo_only = lo_data;
    end
    if (stall) stall_cnt++;
    if (!resetn) begin
      m_rem = 0; m_shown_hi = '0; m_shown_lo = '0; mvalid = 1;
    end else if (flush) begin
      m_rem = 0;
    end else if (m_rem > 0) begin
      if (m_rem == 2) begin m_shown_hi = m_pend_hi; m_shown_lo = m_pend_lo; end
      m_rem--;
    end else if (e_acc && (req_op == 3'd1 || req_op == 3'd2)) begin
      {m_pend_hi, m_pend_lo} = ref_result(req_op, src_a, src_b);
      m_rem = MC + 1;
    end else if (e_acc && (req_op == 3'd3 || req_op == 3'd4)) begin
      {m_pend_hi, m_pend_lo} = ref_result(req_op, src_a, src_b);
      m_rem = 33;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) tick();
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Issue one op and check its single write against literal values.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input string nm);
    int n0, c0;
    wait_idle();
    req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
    n0 = wr_count; c0 = cyc + 1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 60 && wr_count == n0; i++) tick();
    tick(); tick(); tick();
    chk({nm, "_writes"}, 32'(wr_count - n0), 32'd1);
    chk({nm, "_hi"}, last_hi, eh);
    chk({nm, "_lo"}, last_lo, el);
    chk({nm, "_latency"}, 32'(wr_cyc - c0), 32'(lat));
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    int n0, c0, s0;
    resetn = 1'b0;
    tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_stall", {31'd0, stall},     32'd0);
    chk("rst_we",    {30'd0, hi_we, lo_we}, 32'd0);
    chk("rst_hi",    hi_data, 32'd0);
    chk("rst_lo",    lo_data, 32'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MC + 1, "mult");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MC + 1, "multu");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_neg7_2");
    run_op(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 33, "divu_7_2");
    run_op(3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33, "divu_by0");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, "div_ovf");
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, "div_7_neg2");

    // MTHI in idle: combinational write in the accept cycle.
    req_valid = 1'b1; req_op = 3'd5; src_a = 32'h1234;
    @(negedge clk); #1;
    chk("mthi_we",   {31'd0, hi_we}, 32'd1);
    chk("mthi_data", hi_data, 32'h1234);
    chk("mthi_lowe", {31'd0, lo_we}, 32'd0);
    tick();
    req_valid = 1'b0;

    // MTLO held during a DIV: accepted only once idle again (cycle 34).
    wait_idle();
    req_valid = 1'b1; req_op = 3'd4; src_a = 32'd100; src_b = 32'd7;
    c0 = cyc + 1; n0 = lo_only;
    tick();
    req_op = 3'd6; src_a = 32'hBEEF;
    for (int i = 0; i < 60 && !req_ready; i++) tick();
    chk("mtlo_accept_cycle", 32'(cyc + 1 - c0), 32'd34);
    tick();
    req_valid = 1'b0;
    chk("mtlo_count", 32'(lo_only - n0), 32'd1);
    chk("mtlo_data",  last_lo_only, 32'hBEEF);
    chk("divu100_7_lo", last_lo, 32'd14);
    chk("divu100_7_hi", last_hi, 32'd2);

    // Stall covers every busy cycle of a DIV (S_DIV plus S_DONE).
    rd_hilo = 1'b1;
    s0 = stall_cnt;
    run_op(3'd3, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 33, "div_stall");
    chk("stall_cycles", 32'(stall_cnt - s0), 32'd33);

    // Flush in cycle 10 of a DIV: no write, idle next cycle.
    wait_idle();
    req_valid = 1'b1; req_op = 3'd3; src_a = 32'd55; src_b = 32'd5;
    n0 = wr_count;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 40; i++) tick();
    chk("flush_nowrite", 32'(wr_count - n0), 32'd0);
    rd_hilo = 1'b0;

    // Reset mid-multiply: op discarded, result registers cleared.
    req_valid = 1'b1; req_op = 3'd2; src_a = 32'd9; src_b = 32'd9;
    n0 = wr_count;
    tick();
    req_valid = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("rstmid_nowrite", 32'(wr_count - n0), 32'd0);
    chk("rstmid_lo", lo_data, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_op    = 3'($urandom_range(0, 6));
      src_a     = rand_val();
      src_b     = rand_val();
      flush     = ($urandom_range(0, 49) == 0);
      rd_hilo   = $urandom_range(0, 1) != 0;
      resetn    = ($urandom_range(0, 299) != 0);
      tick();
    end
    req_valid = 1'b0; flush = 1'b0; resetn = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
